reg_ronly_bank: RTL

REG_RONLY_BANK -- requirements
Module: reg_ronly_bank

---
 rtl/reg_ronly_bank_if.sv | 19 +
 rtl/reg_ronly_bank.sv | 106 ++++++++++
 2 files changed

// File: rtl/reg_ronly_bank_if.sv
// ---------------------------------------------------------------------------
// reg_ronly_bank_if
// Core-bus read port of the read-only register bank.
//   re     : read enable, driven by the bus master
//   raddr  : channel select, valid while re=1
//   rdata  : combinational read data returned by the bank
// Modports: master (core side), slave (register bank side).
// ---------------------------------------------------------------------------
interface reg_ronly_bank_if #(
    parameter int AW = 2,
    parameter int BW = 8
);
    logic          re;
    logic [AW-1:0] raddr;
    logic [BW-1:0] rdata;

    modport master (output re, output raddr, input  rdata);
    modport slave  (input  re, input  raddr, output rdata);
endinterface

// File: rtl/reg_ronly_bank.sv
// ---------------------------------------------------------------------------
// reg_ronly_bank
// Bank of CH read-only peripheral registers, BW bits each. Each channel is
// either LEVEL (tracks its input, frozen while being read) or STICKY
// (accumulates rising edges, cleared by the read that returns them).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   datain     : CH*BW peripheral inputs, channel k at [k*BW +: BW]
//   bus        : read port (re, raddr, rdata), slave side
//   irq        : registered OR of every STICKY channel register
// ---------------------------------------------------------------------------
module reg_ronly_bank #(
    parameter int              BW     = 8,
    parameter int              CH     = 4,
    parameter int              AW     = 2,
    parameter logic [CH-1:0]   STICKY = {CH{1'b0}}
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [CH*BW-1:0]   datain,
    reg_ronly_bank_if.slave    bus,
    output logic               irq
);

    logic [CH-1:0] sel;       // channel selected this cycle
    logic [CH-1:0] sel_q;     // channel selected last cycle
    logic [CH-1:0] read_end;  // selection just ended

    logic [BW-1:0] data_q [CH];
    logic [BW-1:0] pend_q [CH];  // events seen while a read was in progress
    logic [BW-1:0] prev_q [CH];  // previous input, for edge detection
    logic [BW-1:0] data_d [CH];
    logic [BW-1:0] pend_d [CH];
    logic [BW-1:0] rise   [CH];
    logic          irq_d;

    // An address at or above CH matches no k, so an out-of-range read
    // selects nothing and leaves every channel untouched.
    // NOTE: every combinational output gets a default before the loop so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        sel      = '0;
        read_end = '0;
        for (int k = 0; k < CH; k++) begin
            sel[k]      = bus.re && (bus.raddr == AW'(k));
            read_end[k] = sel_q[k] && !sel[k];
        end
    end

    always_comb begin
        bus.rdata = '0;
        for (int k = 0; k < CH; k++) begin
            if (sel[k]) begin
                bus.rdata = data_q[k];
            end
        end
    end

    always_comb begin
        irq_d = 1'b0;
        for (int k = 0; k < CH; k++) begin
            rise[k]   = datain[k*BW +: BW] & ~prev_q[k];
            data_d[k] = data_q[k];
            pend_d[k] = '0;
            if (STICKY[k]) begin
                if (sel[k]) begin
                    // Frozen for the bus; park new events until the read ends.
                    pend_d[k] = pend_q[k] | rise[k];
                end else if (read_end[k]) begin
                    // Clear what was returned; new events win over the clear.
                    data_d[k] = pend_q[k] | rise[k];
                end else begin
                    data_d[k] = data_q[k] | pend_q[k] | rise[k];
                end
                irq_d = irq_d | (|data_d[k]);
            end else if (!sel[k]) begin
                data_d[k] = datain[k*BW +: BW];
            end
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    // NOTE: the register arrays are small flop banks, not RAM, so they are
    // cleared by the asynchronous reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < CH; k++) begin
                data_q[k] <= '0;
                pend_q[k] <= '0;
                prev_q[k] <= '0;
            end
            sel_q <= '0;
            irq   <= 1'b0;
        end else begin
            for (int k = 0; k < CH; k++) begin
                data_q[k] <= data_d[k];
                pend_q[k] <= pend_d[k];
                prev_q[k] <= datain[k*BW +: BW];
            end
            sel_q <= sel;
            irq   <= irq_d;
        end
    end

endmodule
